cpu_seq_ctrl: RTL and testbench
===============================

CPU_SEQ_CTRL -- requirements
Module: cpu_seq_ctrl

Interface
REQ-001 SHALL have parameter INSTR_W, default 8, instruction/opcode width (minimum 8; decode uses instruction[7:0]).
REQ-002 SHALL have parameter STATE_W, default 8, state code width (minimum 5).
REQ-003 SHALL have parameter CYC_W, default 4, step counter width (minimum 3).
REQ-004 SHALL have port clk  input  1  clock; all state updates on its rising edge.
REQ-005 SHALL have port reset_cycle  input  1  reset; asynchronous, active-high.
REQ-006 SHALL have port instruction  input  INSTR_W  instruction word from memory.
REQ-007 SHALL have port stall  input  1  when high, all registers hold for that cycle.
REQ-008 SHALL have port resume  input  1  releases HALT.
REQ-009 SHALL have port state  output  STATE_W  registered control state code.
REQ-010 SHALL have port cycle  output  CYC_W  registered step index within the instruction.
REQ-011 SHALL have port opcode  output  INSTR_W  latched decoded opcode.
REQ-012 SHALL have ports halted, instr_done, illegal  output  1 each: halt flag, end-of-instruction pulse, undecodable-opcode pulse.

Function
REQ-013 State codes SHALL be: NEXT 00, FETCH_PC 01, FETCH_INST 02, HALT 03, JUMP 04, OUT 05, ALU_OUT 06, ALU_EXEC 07, MOV_STORE 08, MOV_FETCH 09, MOV_LOAD 0A, FETCH_SP 0C, PC_STORE 0D, TMP_JUMP 0E, RET 0F, INC_SP 10, SET_ADDR 11, IN 12, REG_STORE 13, SET_REG 14 (hex, zero-extended to STATE_W).
REQ-014 Decode, priority order: 00_010_xxx LDI(10); 10_xxx_xxx MOV(80); 01_xxx_000 ALU(40); 00_011_xxx JMP(18); 00_100_xxx PUSH(20); 00_101_xxx POP(28); exact 00 NOP, 01 CALL, 02 RET, 03 OUT, 04 IN, 05 HLT, 06 CMP; all other values SHALL be illegal; for classified opcodes the upper INSTR_W-8 bits SHALL be zero.
REQ-015 On each non-stalled edge with cycle=k, state SHALL take step k of the active sequence, and cycle SHALL become k+1, or 0 when step k is NEXT.
REQ-016 Steps 0,1 SHALL be FETCH_PC, FETCH_INST for every instruction; opcode SHALL be latched from instruction on the edge with cycle=1 only.
REQ-017 Steps from 2 SHALL be: MOV 09,0A,08; ALU 07,06; CMP 07; RET 10,0C,0F; POP 10,0C,14; PUSH 0C,13; IN 01,11,12; OUT 01,11,05; CALL 01,14,0C,0D,0E; LDI 01,14; JMP 01,04; HLT 03; NOP/illegal none; each sequence SHALL end with one NEXT step.
REQ-018 instr_done SHALL pulse high for exactly the cycle in which state=NEXT is first presented after a sequence.
REQ-019 illegal SHALL pulse high for one cycle on the edge with cycle=2 when the latched opcode is illegal; the instruction SHALL then execute as NOP.
REQ-020 On entering HALT, halted SHALL go high and state/cycle SHALL hold until a non-stalled edge with resume=1, which SHALL give state=NEXT, cycle=0, halted=0, instr_done=1.
REQ-021 resume while not halted SHALL be ignored.
REQ-022 stall SHALL take priority over resume and sequencing; pulse outputs SHALL be 0 during a stalled cycle.
REQ-023 cycle SHALL never exceed 7; any unreachable step index SHALL force state=NEXT, cycle=0.

Reset
REQ-024 reset_cycle high SHALL immediately set state=00, cycle=0, opcode=0, halted=0, instr_done=0, illegal=0, abandoning any instruction in progress.
REQ-025 After reset deassertion, the first non-stalled edge SHALL present FETCH_PC with cycle=1.

Verification
REQ-026 instruction=8'h12 (LDI), no stall -> state 01,02,01,14,00; opcode=10; instr_done at state 00; cycle 1,2,3,4,0.
REQ-027 instruction=8'h01 (CALL) -> state 01,02,01,14,0C,0D,0E,00; cycle reaches 7 then 0.
REQ-028 instruction=8'h05 (HLT), resume low 10 cycles then high 1 cycle -> state 03, halted=1 held 10 cycles; then state 00, halted=0, instr_done=1.
REQ-029 instruction=8'h07 -> illegal=1 for one cycle, state 01,02,00, instr_done=1.
REQ-030 MOV (8'h8A) with stall high 3 cycles at cycle=3 -> state 09 and cycle 3 frozen 3 cycles, then 0A,08,00 resume.
REQ-031 reset_cycle asserted mid-clock during ALU (8'h48) at state 07 -> outputs zero immediately without clk edge; next edge presents FETCH_PC.

Source files
------------

// File: rtl/cpu_seq_ctrl_if.sv
// Bundle between a microsequencer and the block that drives it.
//   master : drives instruction, stall, resume; observes the sequencer outputs
//   slave  : the sequencer (cpu_seq_ctrl); observes the inputs, drives
//            state, cycle, opcode, halted, instr_done, illegal
interface cpu_seq_ctrl_if #(
  parameter int INSTR_W = 8,
  parameter int STATE_W = 8,
  parameter int CYC_W   = 4
);
  logic [INSTR_W-1:0] instruction;
  logic               stall;
  logic               resume;
  logic [STATE_W-1:0] state;
  logic [CYC_W-1:0]   cycle;
  logic [INSTR_W-1:0] opcode;
  logic               halted;
  logic               instr_done;
  logic               illegal;

  modport master (
    output instruction, stall, resume,
    input  state, cycle, opcode, halted, instr_done, illegal
  );
  modport slave (
    input  instruction, stall, resume,
    output state, cycle, opcode, halted, instr_done, illegal
  );
endinterface

// File: rtl/cpu_seq_ctrl.sv
// CPU microsequencer: steps through FETCH_PC, FETCH_INST and then the
// per-opcode control-state sequence, ending every instruction with one NEXT.
//   clk         : rising-edge clock
//   reset_cycle : asynchronous active-high reset
//   bus (slave) : instruction/stall/resume in; state, cycle, opcode,
//                 halted, instr_done, illegal out (all registered)
module cpu_seq_ctrl #(
  parameter int INSTR_W = 8,
  parameter int STATE_W = 8,
  parameter int CYC_W   = 4
) (
  input  logic           clk,
  input  logic           reset_cycle,
  cpu_seq_ctrl_if.slave  bus
);

  typedef enum logic [4:0] {
    S_NEXT      = 5'h00, S_FETCH_PC  = 5'h01, S_FETCH_INST = 5'h02,
    S_HALT      = 5'h03, S_JUMP      = 5'h04, S_OUT        = 5'h05,
    S_ALU_OUT   = 5'h06, S_ALU_EXEC  = 5'h07, S_MOV_STORE  = 5'h08,
    S_MOV_FETCH = 5'h09, S_MOV_LOAD  = 5'h0A, S_FETCH_SP   = 5'h0C,
    S_PC_STORE  = 5'h0D, S_TMP_JUMP  = 5'h0E, S_RET        = 5'h0F,
    S_INC_SP    = 5'h10, S_SET_ADDR  = 5'h11, S_IN         = 5'h12,
    S_REG_STORE = 5'h13, S_SET_REG   = 5'h14
  } st_e;

  typedef enum logic [3:0] {
    C_NOP, C_CALL, C_RET, C_OUT, C_IN, C_HLT, C_CMP,
    C_LDI, C_MOV, C_ALU, C_JMP, C_PUSH, C_POP, C_ILL
  } cls_e;

  // casez order is the decode priority
  function automatic cls_e classify(input logic [INSTR_W-1:0] i);
    if ((i >> 8) != '0) return C_ILL;
    casez (i[7:0])
      8'b00_010_???: return C_LDI;
      8'b10_???_???: return C_MOV;
      8'b01_???_000: return C_ALU;
      8'b00_011_???: return C_JMP;
      8'b00_100_???: return C_PUSH;
      8'b00_101_???: return C_POP;
      8'h00:         return C_NOP;
      8'h01:         return C_CALL;
      8'h02:         return C_RET;
      8'h03:         return C_OUT;
      8'h04:         return C_IN;
      8'h05:         return C_HLT;
      8'h06:         return C_CMP;
      default:       return C_ILL;
    endcase
  endfunction

  // Range classes collapse to their base code; exact and illegal values
  // are kept verbatim so re-classifying the latched opcode is lossless.
  function automatic logic [INSTR_W-1:0] canon(input logic [INSTR_W-1:0] i);
    case (classify(i))
      C_LDI:   return INSTR_W'(8'h10);
      C_MOV:   return INSTR_W'(8'h80);
      C_ALU:   return INSTR_W'(8'h40);
      C_JMP:   return INSTR_W'(8'h18);
      C_PUSH:  return INSTR_W'(8'h20);
      C_POP:   return INSTR_W'(8'h28);
      default: return i;
    endcase
  endfunction

  // Control state for step k (k >= 2); anything past a sequence is NEXT.
  function automatic st_e step_of(input cls_e c, input int k);
    st_e s;
    s = S_NEXT;
    case (c)
      C_MOV:  case (k) 2: s = S_MOV_FETCH; 3: s = S_MOV_LOAD; 4: s = S_MOV_STORE; default: ; endcase
      C_ALU:  case (k) 2: s = S_ALU_EXEC;  3: s = S_ALU_OUT;  default: ; endcase
      C_CMP:  case (k) 2: s = S_ALU_EXEC;  default: ; endcase
      C_RET:  case (k) 2: s = S_INC_SP;    3: s = S_FETCH_SP; 4: s = S_RET;       default: ; endcase
      C_POP:  case (k) 2: s = S_INC_SP;    3: s = S_FETCH_SP; 4: s = S_SET_REG;   default: ; endcase
      C_PUSH: case (k) 2: s = S_FETCH_SP;  3: s = S_REG_STORE; default: ; endcase
      C_IN:   case (k) 2: s = S_FETCH_PC;  3: s = S_SET_ADDR; 4: s = S_IN;        default: ; endcase
      C_OUT:  case (k) 2: s = S_FETCH_PC;  3: s = S_SET_ADDR; 4: s = S_OUT;       default: ; endcase
      C_CALL: case (k)
                2: s = S_FETCH_PC; 3: s = S_SET_REG;  4: s = S_FETCH_SP;
                5: s = S_PC_STORE; 6: s = S_TMP_JUMP; default: ;
              endcase
      C_LDI:  case (k) 2: s = S_FETCH_PC;  3: s = S_SET_REG;  default: ; endcase
      C_JMP:  case (k) 2: s = S_FETCH_PC;  3: s = S_JUMP;     default: ; endcase
      C_HLT:  case (k) 2: s = S_HALT;      default: ; endcase
      default: ;
    endcase
    return s;
  endfunction

  st_e                st_q, st_d, step;
  logic [CYC_W-1:0]   cyc_q, cyc_d;
  logic [INSTR_W-1:0] opc_q, opc_d;
  logic               halt_q, halt_d, done_q, done_d, ill_q, ill_d;
  cls_e               cls_q;

  assign cls_q = classify(opc_q);

  always_ff @(posedge clk or posedge reset_cycle) begin
    if (reset_cycle) begin
      st_q   <= S_NEXT;
      cyc_q  <= '0;
      opc_q  <= '0;
      halt_q <= 1'b0;
      done_q <= 1'b0;
      ill_q  <= 1'b0;
    end else begin
      st_q   <= st_d;
      cyc_q  <= cyc_d;
      opc_q  <= opc_d;
      halt_q <= halt_d;
      done_q <= done_d;
      ill_q  <= ill_d;
    end
  end

  // Stall holds everything except the pulses, which drop to zero.
  always_comb begin
    st_d   = st_q;
    cyc_d  = cyc_q;
    opc_d  = opc_q;
    halt_d = halt_q;
    done_d = 1'b0;
    ill_d  = 1'b0;
    step   = S_NEXT;
    if (!bus.stall) begin
      if (halt_q) begin
        if (bus.resume) begin
          st_d   = S_NEXT;
          cyc_d  = '0;
          halt_d = 1'b0;
          done_d = 1'b1;
        end
      end else if (int'(cyc_q) > 7) begin
        st_d  = S_NEXT;
        cyc_d = '0;
      end else begin
        if (cyc_q == CYC_W'(0))      step = S_FETCH_PC;
        else if (cyc_q == CYC_W'(1)) step = S_FETCH_INST;
        else                         step = step_of(cls_q, int'(cyc_q));
        st_d = step;
        if (step == S_NEXT) begin
          cyc_d  = '0;
          done_d = 1'b1;
        end else begin
          cyc_d = cyc_q + 1'b1;
        end
        if (step == S_HALT) halt_d = 1'b1;
        if (cyc_q == CYC_W'(1)) opc_d = canon(bus.instruction);
        if (cyc_q == CYC_W'(2) && cls_q == C_ILL) ill_d = 1'b1;
      end
    end
  end

  assign bus.state      = STATE_W'(st_q);
  assign bus.cycle      = cyc_q;
  assign bus.opcode     = opc_q;
  assign bus.halted     = halt_q;
  assign bus.instr_done = done_q;
  assign bus.illegal    = ill_q;

endmodule

// File: tb/tb_cpu_seq_ctrl.sv
// Testbench for cpu_seq_ctrl: directed scenarios plus random stimulus,
// all outputs compared every cycle with a sequence-table reference model.
module tb_cpu_seq_ctrl;
  logic clk = 1'b0;
  logic reset_cycle;
  always #5 clk = ~clk;

  cpu_seq_ctrl_if #(.INSTR_W(8), .STATE_W(8), .CYC_W(4)) bus ();
  cpu_seq_ctrl #(.INSTR_W(8), .STATE_W(8), .CYC_W(4)) dut (
    .clk(clk), .reset_cycle(reset_cycle), .bus(bus));

  int n_chk = 0, n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef int iq_t[$];
  int  m_state, m_cycle, m_opc, m_halt, m_done, m_ill;
  bit  m_bad;
  iq_t seq;

  // -1 marks an illegal opcode
  function automatic int canon_of(input int op);
    if (op >= 'h10 && op <= 'h17) return 'h10;
    if (op >= 'h80 && op <= 'hBF) return 'h80;
    if (op >= 'h40 && op <= 'h7F && op % 8 == 0) return 'h40;
    if (op >= 'h18 && op <= 'h1F) return 'h18;
    if (op >= 'h20 && op <= 'h27) return 'h20;
    if (op >= 'h28 && op <= 'h2F) return 'h28;
    if (op >= 0 && op <= 6) return op;
    return -1;
  endfunction

  // full per-step state list for one instruction: fetch, body, NEXT
  function automatic iq_t seq_of(input int c);
    iq_t body, s;
    case (c)
      'h80: body = '{'h09, 'h0A, 'h08};
      'h40: body = '{'h07, 'h06};
      6:    body = '{'h07};
      2:    body = '{'h10, 'h0C, 'h0F};
      'h28: body = '{'h10, 'h0C, 'h14};
      'h20: body = '{'h0C, 'h13};
      4:    body = '{'h01, 'h11, 'h12};
      3:    body = '{'h01, 'h11, 'h05};
      1:    body = '{'h01, 'h14, 'h0C, 'h0D, 'h0E};
      'h10: body = '{'h01, 'h14};
      'h18: body = '{'h01, 'h04};
      5:    body = '{'h03};
      default: body = {};
    endcase
    s = '{'h01, 'h02};
    foreach (body[i]) s.push_back(body[i]);
    s.push_back(0);
    return s;
  endfunction

  task automatic model_reset();
    m_state = 0; m_cycle = 0; m_opc = 0; m_halt = 0; m_done = 0; m_ill = 0;
    m_bad = 0; seq = '{'h01, 'h02, 0};
  endtask

  task automatic model_edge(input int instr, input bit st, input bit rs);
    int c;
    m_done = 0; m_ill = 0;
    if (st) return;
    if (m_halt) begin
      if (rs) begin m_state = 0; m_cycle = 0; m_halt = 0; m_done = 1; end
      return;
    end
    if (m_cycle == 1) begin
      c = canon_of(instr);
      m_bad = (c < 0);
      m_opc = m_bad ? instr : c;
      seq = seq_of(c);
    end
    m_state = (m_cycle < seq.size()) ? seq[m_cycle] : 0;
    if (m_cycle == 2 && m_bad) m_ill = 1;
    if (m_state == 0) begin m_cycle = 0; m_done = 1; end
    else m_cycle++;
    if (m_state == 3) m_halt = 1;
  endtask

  task automatic chk_all(input string tag);
    chk({tag, ".state"},  32'(bus.state),      32'(m_state));
    chk({tag, ".cycle"},  32'(bus.cycle),      32'(m_cycle));
    chk({tag, ".opcode"}, 32'(bus.opcode),     32'(m_opc));
    chk({tag, ".halted"}, 32'(bus.halted),     32'(m_halt));
    chk({tag, ".done"},   32'(bus.instr_done), 32'(m_done));
    chk({tag, ".ill"},    32'(bus.illegal),    32'(m_ill));
  endtask

  // drive, clock, update model, check on the falling edge
  task automatic tick(input string tag, input int instr, input bit st, input bit rs);
    bus.instruction = 8'(instr);
    bus.stall = st;
    bus.resume = rs;
    @(posedge clk);
    model_edge(instr, st, rs);
    @(negedge clk);
    chk_all(tag);
  endtask

  int exp_st[5] = '{'h01, 'h02, 'h01, 'h14, 'h00};
  int exp_cy[5] = '{1, 2, 3, 4, 0};
  int ops[14]   = '{'h00, 'h01, 'h02, 'h03, 'h04, 'h05, 'h06,
                    'h12, 'h8A, 'h48, 'h1B, 'h23, 'h2D, 'h07};

  initial begin
    bus.instruction = '0; bus.stall = 0; bus.resume = 0;
    reset_cycle = 1'b1;
    model_reset();
    @(negedge clk); @(negedge clk);
    chk_all("reset");
    reset_cycle = 1'b0;

    // LDI with explicit trace
    for (int i = 0; i < 5; i++) begin
      tick("ldi", 'h12, 0, 0);
      chk("ldi_trace_st", 32'(bus.state), 32'(exp_st[i]));
      chk("ldi_trace_cy", 32'(bus.cycle), 32'(exp_cy[i]));
    end
    chk("ldi_opcode", 32'(bus.opcode), 32'h10);
    chk("ldi_done", 32'(bus.instr_done), 32'd1);

    // CALL reaches cycle 7
    for (int i = 0; i < 7; i++) tick("call", 'h01, 0, 0);
    chk("call_cyc7", 32'(bus.cycle), 32'd7);
    tick("call", 'h01, 0, 0);
    chk("call_next", 32'(bus.state), 32'h0);

    // HLT held 10 cycles, then resume
    for (int i = 0; i < 3; i++) tick("hlt", 'h05, 0, 0);
    for (int i = 0; i < 10; i++) begin
      tick("hlt_hold", 'h05, 0, 0);
      chk("hlt_halted", 32'(bus.halted), 32'd1);
      chk("hlt_state", 32'(bus.state), 32'h03);
    end
    tick("hlt_res", 'h05, 0, 1);
    chk("hlt_res_done", 32'(bus.instr_done), 32'd1);
    chk("hlt_res_halted", 32'(bus.halted), 32'd0);

    // illegal 0x07
    tick("ill", 'h07, 0, 0);
    tick("ill", 'h07, 0, 0);
    tick("ill", 'h07, 0, 0);
    chk("ill_pulse", 32'(bus.illegal), 32'd1);
    chk("ill_next", 32'(bus.state), 32'h00);
    tick("ill", 'h00, 0, 0);
    chk("ill_once", 32'(bus.illegal), 32'd0);

    // MOV stalled at cycle 3 (tick above already started a NOP fetch)
    tick("nop", 'h00, 0, 0);
    tick("nop", 'h00, 0, 0);
    for (int i = 0; i < 3; i++) tick("mov", 'h8A, 0, 0);
    for (int i = 0; i < 3; i++) begin
      tick("mov_stall", 'h8A, 1, 1);
      chk("mov_stall_st", 32'(bus.state), 32'h09);
      chk("mov_stall_cy", 32'(bus.cycle), 32'd3);
    end
    for (int i = 0; i < 3; i++) tick("mov", 'h8A, 0, 0);
    chk("mov_end", 32'(bus.state), 32'h00);

    // async reset mid-ALU at state 07
    for (int i = 0; i < 3; i++) tick("alu", 'h48, 0, 0);
    chk("alu_exec", 32'(bus.state), 32'h07);
    #1 reset_cycle = 1'b1;
    model_reset();
    #1 chk_all("async_rst");
    #1 reset_cycle = 1'b0;
    tick("post_rst", 'h48, 0, 0);
    chk("post_rst_fetch", 32'(bus.state), 32'h01);

    // random stimulus
    for (int n = 0; n < 2000; n++) begin
      int op;
      op = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 255))
                                       : ops[$urandom_range(0, 13)];
      tick("rnd", op, ($urandom_range(0, 4) == 0), ($urandom_range(0, 5) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end
endmodule
